// File: rtl/cbus_sim_ram_if.sv
// Cache-bus types and the request/response bundle between a cache master and a memory responder.
// The master drives creq and holds it stable until the last beat; the responder answers with cresp.
package cbus_pkg;
  typedef logic [63:0] word_t;

  typedef enum logic [1:0] {
    CBUS_FIXED = 2'd0,
    CBUS_INCR  = 2'd1,
    CBUS_WRAP  = 2'd2
  } cbus_burst_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    word_t       data;
    logic [3:0]  len;
    cbus_burst_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic  ready;
    logic  last;
    word_t data;
  } cbus_resp_t;
endpackage

// Handshake: a request is taken when creq.valid is seen in IDLE; each cycle with
// cresp.ready=1 is one beat (write data consumed at that edge, read data valid in
// that cycle); cresp.last marks the final beat, after which the master may change creq.
interface cbus_sim_ram_if;
  import cbus_pkg::*;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  modport master (output creq, input cresp);
  modport slave  (input creq, output cresp);
endinterface

// File: rtl/cbus_sim_ram.sv
// Word-addressed 64-bit RAM answering cache-bus single and burst transactions
// with a fixed first-beat latency of DELAY idle cycles.
module cbus_sim_ram
  import cbus_pkg::*;
#(
  parameter int WORDS_LOG = 10,
  parameter int DELAY     = 2
) (
  input  logic           clk,
  input  logic           reset,
  cbus_sim_ram_if.slave  bus,
  output logic [1:0]     dbg_state
);

  localparam int WORDS = 2 ** WORDS_LOG;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2
  } state_t;

  state_t                 state;
  logic [3:0]             cnt;
  logic [3:0]             beat;
  logic [3:0]             l_len;
  logic                   l_write;
  cbus_burst_t            l_burst;
  logic [WORDS_LOG-1:0]   idx;
  logic [WORDS_LOG-1:0]   bidx;
  logic [WORDS_LOG-1:0]   lin_idx;
  logic [WORDS_LOG-1:0]   wrap_mask;
  logic                   wrap_ok;
  logic                   ready_q;
  logic                   last_q;

  word_t mem [WORDS];

  // Address bits above the array and the byte offset are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.creq.addr[63:WORDS_LOG+3], bus.creq.addr[2:0], bus.creq.size};

  assign dbg_state = state;

  // Beat word index; a WRAP with a non power-of-two length falls back to INCR.
  always_comb begin
    lin_idx   = idx + WORDS_LOG'(beat);
    wrap_mask = WORDS_LOG'(l_len);
    wrap_ok   = (l_len == 4'd1) || (l_len == 4'd3) || (l_len == 4'd7) || (l_len == 4'd15);
    bidx      = lin_idx;
    case (l_burst)
      CBUS_FIXED: bidx = idx;
      CBUS_WRAP:  if (wrap_ok) bidx = (idx & ~wrap_mask) | (lin_idx & wrap_mask);
      default:    bidx = lin_idx;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      beat    <= 4'd0;
      l_len   <= 4'd0;
      l_write <= 1'b0;
      l_burst <= CBUS_FIXED;
      idx     <= '0;
      ready_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.creq.valid) begin
            l_write <= bus.creq.is_write;
            l_len   <= bus.creq.len;
            l_burst <= bus.creq.burst;
            idx     <= bus.creq.addr[WORDS_LOG+2:3];
            beat    <= 4'd0;
            if (DELAY == 0) begin
              state   <= S_BURST;
              ready_q <= 1'b1;
              last_q  <= (bus.creq.len == 4'd0);
            end else begin
              state <= S_WAIT;
              cnt   <= 4'(DELAY - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state   <= S_BURST;
            ready_q <= 1'b1;
            last_q  <= (l_len == 4'd0);
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_BURST: begin
          if (beat == l_len) begin
            state   <= S_IDLE;
            beat    <= 4'd0;
            ready_q <= 1'b0;
            last_q  <= 1'b0;
          end else begin
            beat   <= beat + 4'd1;
            last_q <= ((beat + 4'd1) == l_len);
          end
        end
        default: begin
          state   <= S_IDLE;
          ready_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  // Storage is never reset; a reset mid-burst keeps whatever beats already landed.
  always_ff @(posedge clk) begin
    if (state == S_BURST && l_write) begin
      for (int k = 0; k < 8; k++) begin
        if (bus.creq.strobe[k]) mem[bidx][8*k +: 8] <= bus.creq.data[8*k +: 8];
      end
    end
  end

  always_comb begin
    bus.cresp.ready = ready_q;
    bus.cresp.last  = last_q;
    bus.cresp.data  = (state == S_BURST) ? mem[bidx] : '0;
  end

endmodule

// File: tb/tb_cbus_sim_ram.sv
// Directed bench for cbus_sim_ram: latency, INCR/FIXED/WRAP bursts, byte strobes,
// address aliasing, back-to-back requests with zero latency and reset mid-burst.
module tb_cbus_sim_ram;
  import cbus_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cbus_sim_ram_if bus ();
  cbus_sim_ram_if bus0 ();
  logic [1:0] dbg;
  logic [1:0] dbg0;

  cbus_sim_ram #(.WORDS_LOG(10), .DELAY(2)) dut (
    .clk(clk), .reset(rst), .bus(bus), .dbg_state(dbg));

  cbus_sim_ram #(.WORDS_LOG(10), .DELAY(0)) dut0 (
    .clk(clk), .reset(rst), .bus(bus0), .dbg_state(dbg0));

  int    checks = 0;
  int    errors = 0;
  word_t wdata [16];
  word_t rdata [16];
  int    first_k;
  int    last_k;
  int    nbeats;

  task automatic wr_burst(input logic [63:0] addr, input logic [3:0] len,
                          input cbus_burst_t burst, input logic [7:0] strobe);
    int beat;
    int guard;
    @(negedge clk);
    bus.creq.valid    = 1'b1;
    bus.creq.is_write = 1'b1;
    bus.creq.addr     = addr;
    bus.creq.size     = 3'd3;
    bus.creq.len      = len;
    bus.creq.burst    = burst;
    bus.creq.strobe   = strobe;
    bus.creq.data     = wdata[0];
    @(posedge clk);
    @(negedge clk);
    bus.creq.valid = 1'b0;
    beat  = 0;
    guard = 0;
    while (beat <= int'(len) && guard < 64) begin
      if (bus.cresp.ready) begin
        @(posedge clk);
        #1;
        beat++;
        if (beat < 16) bus.creq.data = wdata[beat];
      end
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 64) begin
      errors++;
      $display("FAIL wr_timeout: beats done %0d, required %0d", beat, int'(len) + 1);
    end
    bus.creq = '0;
  endtask

  task automatic rd_burst(input logic [63:0] addr, input logic [3:0] len, input cbus_burst_t burst);
    first_k = -1;
    last_k  = -1;
    nbeats  = 0;
    for (int i = 0; i < 16; i++) rdata[i] = '0;
    @(negedge clk);
    bus.creq.valid    = 1'b1;
    bus.creq.is_write = 1'b0;
    bus.creq.addr     = addr;
    bus.creq.size     = 3'd3;
    bus.creq.len      = len;
    bus.creq.burst    = burst;
    bus.creq.strobe   = 8'h00;
    bus.creq.data     = '0;
    @(posedge clk);
    @(negedge clk);
    bus.creq.valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (bus.cresp.ready) begin
        if (first_k < 0) first_k = k;
        if (nbeats < 16) rdata[nbeats] = bus.cresp.data;
        if (bus.cresp.last && last_k < 0) last_k = k;
        nbeats++;
      end
      if (last_k >= 0 && k > last_k) break;
    end
    checks++;
    if (last_k < 0) begin
      errors++;
      $display("FAIL rd_timeout: no last beat seen, beats %0d", nbeats);
    end
    bus.creq = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.creq  = '0;
    bus0.creq = '0;
    repeat (2) @(negedge clk);
    checks++; if (dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg); end
    checks++; if (bus.cresp.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.cresp.ready); end
    checks++; if (bus.cresp.last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", bus.cresp.last); end
    checks++; if (bus.cresp.data !== 64'h0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.cresp.data); end
    checks++; if (bus0.cresp.ready !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b want 0", bus0.cresp.ready); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    wdata[0] = 64'h1122334455667788;
    wr_burst(64'h20, 4'd0, CBUS_INCR, 8'hFF);
    rd_burst(64'h20, 4'd0, CBUS_INCR);
    checks++; if (first_k !== 3) begin errors++; $display("FAIL single_first_ready: got cycle %0d want 3", first_k); end
    checks++; if (last_k !== 3) begin errors++; $display("FAIL single_last: got cycle %0d want 3", last_k); end
    checks++; if (nbeats !== 1) begin errors++; $display("FAIL single_beats: got %0d want 1", nbeats); end
    checks++; if (rdata[0] !== 64'h1122334455667788) begin errors++; $display("FAIL single_data: got %h want 1122334455667788", rdata[0]); end
  endtask

  task automatic test_incr();
    for (int i = 0; i < 16; i++) wdata[i] = 64'(i);
    wr_burst(64'h100, 4'd15, CBUS_INCR, 8'hFF);
    rd_burst(64'h100, 4'd15, CBUS_INCR);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rdata[i] !== 64'(i)) begin errors++; $display("FAIL incr_beat%0d: got %h want %h", i, rdata[i], 64'(i)); end
    end
    checks++; if (first_k !== 3) begin errors++; $display("FAIL incr_first_ready: got %0d want 3", first_k); end
    checks++; if (last_k !== 18) begin errors++; $display("FAIL incr_last: got cycle %0d want 18", last_k); end
    checks++; if (nbeats !== 16) begin errors++; $display("FAIL incr_beats: got %0d want 16", nbeats); end
  endtask

  task automatic test_strobe();
    wdata[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    wr_burst(64'h40, 4'd0, CBUS_INCR, 8'hFF);
    wdata[0] = 64'h0;
    wr_burst(64'h40, 4'd0, CBUS_INCR, 8'h0F);
    checks++; if (dut.mem[8] !== 64'hFFFFFFFF00000000) begin errors++; $display("FAIL strobe_mem8: got %h want ffffffff00000000", dut.mem[8]); end
    rd_burst(64'h40, 4'd0, CBUS_INCR);
    checks++; if (rdata[0] !== 64'hFFFFFFFF00000000) begin errors++; $display("FAIL strobe_read: got %h want ffffffff00000000", rdata[0]); end
  endtask

  task automatic test_wrap();
    wdata[0] = 64'hAAAA_0000_0000_000A;
    wdata[1] = 64'hBBBB_0000_0000_000B;
    wdata[2] = 64'hCCCC_0000_0000_000C;
    wdata[3] = 64'hDDDD_0000_0000_000D;
    wdata[4] = 64'hEEEE_0000_0000_000E;
    wr_burst(64'h40, 4'd4, CBUS_INCR, 8'hFF);
    rd_burst(64'h50, 4'd3, CBUS_WRAP);
    checks++; if (rdata[0] !== 64'hCCCC_0000_0000_000C) begin errors++; $display("FAIL wrap_beat0: got %h want C", rdata[0]); end
    checks++; if (rdata[1] !== 64'hDDDD_0000_0000_000D) begin errors++; $display("FAIL wrap_beat1: got %h want D", rdata[1]); end
    checks++; if (rdata[2] !== 64'hAAAA_0000_0000_000A) begin errors++; $display("FAIL wrap_beat2: got %h want A", rdata[2]); end
    checks++; if (rdata[3] !== 64'hBBBB_0000_0000_000B) begin errors++; $display("FAIL wrap_beat3: got %h want B", rdata[3]); end
    rd_burst(64'h50, 4'd2, CBUS_WRAP);
    checks++; if (rdata[2] !== 64'hEEEE_0000_0000_000E) begin errors++; $display("FAIL wrap_len3_as_incr: got %h want E", rdata[2]); end
    checks++; if (nbeats !== 3) begin errors++; $display("FAIL wrap_len3_beats: got %0d want 3", nbeats); end
  endtask

  task automatic test_fixed_alias();
    wdata[0] = 64'd5; wdata[1] = 64'd6; wdata[2] = 64'd7; wdata[3] = 64'd8;
    wr_burst(64'h300, 4'd3, CBUS_FIXED, 8'hFF);
    rd_burst(64'h300, 4'd1, CBUS_FIXED);
    checks++; if (rdata[0] !== 64'd8 || rdata[1] !== 64'd8) begin errors++; $display("FAIL fixed_read: got %h %h want 8 8", rdata[0], rdata[1]); end
    checks++; if (dut.mem[97] === 64'd6) begin errors++; $display("FAIL fixed_spill: mem[97] got %h want not 6", dut.mem[97]); end
    rd_burst(64'h2020, 4'd0, CBUS_INCR);
    checks++; if (rdata[0] !== 64'h1122334455667788) begin errors++; $display("FAIL alias_read: got %h want 1122334455667788", rdata[0]); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus0.creq.valid    = 1'b1;
    bus0.creq.is_write = 1'b1;
    bus0.creq.addr     = 64'h8;
    bus0.creq.size     = 3'd3;
    bus0.creq.len      = 4'd0;
    bus0.creq.burst    = CBUS_INCR;
    bus0.creq.strobe   = 8'hFF;
    bus0.creq.data     = 64'h1111;
    @(negedge clk);
    checks++; if (bus0.cresp.ready !== 1'b1) begin errors++; $display("FAIL b2b_wr1_ready: got %b want 1", bus0.cresp.ready); end
    @(negedge clk);
    bus0.creq.addr = 64'h10;
    bus0.creq.data = 64'h2222;
    @(negedge clk);
    checks++; if (bus0.cresp.ready !== 1'b1) begin errors++; $display("FAIL b2b_wr2_ready: got %b want 1", bus0.cresp.ready); end
    bus0.creq.valid = 1'b0;
    @(negedge clk);
    bus0.creq.valid    = 1'b1;
    bus0.creq.is_write = 1'b0;
    bus0.creq.addr     = 64'h8;
    bus0.creq.strobe   = 8'h00;
    @(negedge clk);
    checks++; if (bus0.cresp.ready !== 1'b1 || bus0.cresp.last !== 1'b1) begin errors++; $display("FAIL b2b_rd1_ready_last: got %b%b want 11", bus0.cresp.ready, bus0.cresp.last); end
    checks++; if (bus0.cresp.data !== 64'h1111) begin errors++; $display("FAIL b2b_rd1_data: got %h want 1111", bus0.cresp.data); end
    @(negedge clk);
    checks++; if (bus0.cresp.ready !== 1'b0 || dbg0 !== 2'd0) begin errors++; $display("FAIL b2b_gap: ready %b state %0d want 0 0", bus0.cresp.ready, dbg0); end
    bus0.creq.addr = 64'h10;
    @(negedge clk);
    checks++; if (bus0.cresp.ready !== 1'b1) begin errors++; $display("FAIL b2b_rd2_ready: got %b want 1", bus0.cresp.ready); end
    checks++; if (bus0.cresp.data !== 64'h2222) begin errors++; $display("FAIL b2b_rd2_data: got %h want 2222", bus0.cresp.data); end
    bus0.creq.valid = 1'b0;
    @(negedge clk);
    checks++; if (bus0.cresp.ready !== 1'b0) begin errors++; $display("FAIL b2b_end_ready: got %b want 0", bus0.cresp.ready); end
    bus0.creq = '0;
  endtask

  task automatic test_reset_mid_burst();
    word_t nd [16];
    int    beat;
    int    guard;
    for (int i = 0; i < 16; i++) begin
      wdata[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
      nd[i]    = 64'h5A5A_0000_0000_0100 | 64'(i);
    end
    wr_burst(64'h200, 4'd15, CBUS_INCR, 8'hFF);
    @(negedge clk);
    bus.creq.valid    = 1'b1;
    bus.creq.is_write = 1'b1;
    bus.creq.addr     = 64'h200;
    bus.creq.size     = 3'd3;
    bus.creq.len      = 4'd15;
    bus.creq.burst    = CBUS_INCR;
    bus.creq.strobe   = 8'hFF;
    bus.creq.data     = nd[0];
    @(posedge clk);
    @(negedge clk);
    bus.creq.valid = 1'b0;
    beat  = 0;
    guard = 0;
    while (beat < 3 && guard < 40) begin
      if (bus.cresp.ready) begin
        @(posedge clk);
        #1;
        beat++;
        bus.creq.data = nd[beat];
      end
      @(negedge clk);
      guard++;
    end
    checks++; if (guard >= 40) begin errors++; $display("FAIL rst_mid_timeout: beats %0d want 3", beat); end
    rst = 1'b1;
    #1;
    checks++; if (bus.cresp.ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b want 0", bus.cresp.ready); end
    checks++; if (dbg !== 2'd0) begin errors++; $display("FAIL rst_mid_state: got %0d want 0", dbg); end
    @(negedge clk);
    rst = 1'b0;
    bus.creq = '0;
    rd_burst(64'h200, 4'd15, CBUS_INCR);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i < 3) begin
        if (rdata[i] !== nd[i]) begin errors++; $display("FAIL rst_mid_beat%0d: got %h want %h", i, rdata[i], nd[i]); end
      end else begin
        if (rdata[i] !== wdata[i]) begin errors++; $display("FAIL rst_mid_beat%0d: got %h want %h", i, rdata[i], wdata[i]); end
      end
    end
    checks++; if (last_k !== 18) begin errors++; $display("FAIL rst_mid_next_last: got cycle %0d want 18", last_k); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_incr();
    test_strobe();
    test_wrap();
    test_fixed_alias();
    test_back_to_back();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
